instr_issue_unit: RTL
=====================

# instr_issue_unit

Sequencer directly downstream of the fetch unit's instruction BRAM. On the fetch unit's `VALID_FU2PE` pulse it walks the instruction BRAM from address 0 and decodes each word. It hands compute instructions to the PE array over a valid/ready handshake, drops NOPs, expands REPEAT prefixes and stops at HALT. It owns the BRAM read port (port B); the fetch unit owns the write port.

## Interface
- `INSTR_BRAM_DEPTH`, 11, instruction BRAM address width; program space 2^INSTR_BRAM_DEPTH words
- `S_AXIS_ACLK`  in  1  clock, shared with the fetch unit
- `S_AXIS_ARESETN`  in  1  reset, asynchronous, active-low
- `VALID_FU2PE`  in  1  start pulse from the fetch unit (instruction load complete)
- `instr_rd_addr`  out  INSTR_BRAM_DEPTH  BRAM read address
- `instr_rd_en`  out  1  BRAM read enable
- `instr_dout`  in  32  BRAM read data, valid one cycle after `instr_rd_en`
- `issue_valid`  out  1  instruction available to the PE array
- `issue_ready`  in  1  PE array accepts
- `issue_data`  out  32  instruction word being issued
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse when the program ends
- `err`  out  1  sticky: program ran off the end without HALT

## Operation
- Instruction format: opcode = [31:28], argument = [27:0].
  - 0x0 NOP: skipped, never issued.
  - 0xD REPEAT: rpt_cnt <= [15:0].
  - 0xF HALT: ends the program.
  - All other opcodes are issued as-is.
- States:
  - IDLE: on `VALID_FU2PE` set pc=0, rpt_cnt=0, err=0, go to FETCH. Otherwise stay.
  - FETCH: `instr_rd_en`=1, `instr_rd_addr`=pc. Go to DECODE.
  - DECODE: `instr_dout` is valid this cycle.
    - NOP or REPEAT: act as above, then advance.
    - HALT: go to DONE.
    - Compute: latch the word into `issue_data`, go to ISSUE.
  - ISSUE: `issue_valid`=1. On handshake (valid & ready):
    - if rpt_cnt≠0: rpt_cnt-1, stay in ISSUE with the same word.
    - else: advance.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Advance:
  - If pc ≠ all-ones: pc+1, go to FETCH.
  - If pc = all-ones: err<=1, go to DONE. The pc does not wrap.
- REPEAT semantics:
  - REPEAT n means the next compute instruction issues n+1 times; n=0 gives a single issue.
  - REPEAT followed by REPEAT: the later one overwrites the count.
  - NOP between REPEAT and the compute instruction does not consume the count.
  - A pending count is discarded at HALT or at the next start.
- HALT located at the last address is a normal end: err stays 0.
- `VALID_FU2PE` in any state other than IDLE is ignored.
- `issue_valid` never deasserts without a handshake; `issue_data` is stable while `issue_valid`=1 and not ready.
- `err` holds until the next accepted start.

## Timing
- Reset (async assert, synchronous release): state IDLE. All outputs 0: `instr_rd_addr`, `instr_rd_en`, `issue_valid`, `issue_data`, `busy`, `done`, `err`. pc=0, rpt_cnt=0.
- Reset asserted mid-program: outputs drop to 0 immediately, with no clock edge required. The dropped `issue_valid` is a legal abort.
- Start accepted at edge t: FETCH at t+1, DECODE at t+2, `issue_valid` first high at t+3.
- Per issued instruction with `issue_ready` held high: 3 cycles (FETCH, DECODE, ISSUE).
- Each skipped NOP or REPEAT costs 2 cycles.
- Repeated issues: back-to-back, one handshake per cycle while ready.
- HALT seen in DECODE at cycle c: `done`=1 at c+1, `busy`=0 at c+2.
- `busy` rises the cycle after start and falls the cycle after `done`.

## Test plan
- Reset: hold `S_AXIS_ARESETN`=0 with random inputs -> every output 0. Release, pulse `VALID_FU2PE` -> `busy`=1 next cycle.
- Basic program: BRAM[0..2] = 0x1000_0005, 0x2000_0006, 0xF000_0000; ready=1; start at t.
  - `issue_valid` with data 0x1000_0005 at t+3.
  - `issue_valid` with data 0x2000_0006 at t+6.
  - `done` at t+9, `err`=0, exactly 2 handshakes.
- Backpressure: same program with ready low for 5 cycles while `issue_valid`=1 -> valid and data held stable. Handshake on the first ready cycle. No instruction lost or duplicated.
- REPEAT/NOP: BRAM = 0xD000_0003, 0x0000_0000, 0x3000_0001, 0xF000_0000; ready=1 -> four consecutive-cycle handshakes of 0x3000_0001, then `done`, `err`=0.
- Run-off: INSTR_BRAM_DEPTH=3, all 8 words 0x1000_00xx -> 8 issues in address order, then `done` with `err`=1. `err` cleared by the next start.
- Abort/ignore:
  - Pulse `VALID_FU2PE` during ISSUE -> no effect on pc or issued sequence.
  - Assert reset mid-ISSUE -> `issue_valid`/`busy` 0 immediately.
  - A restart after reset runs from address 0.

Source files
------------

// File: rtl/instr_issue_unit.sv
// Walks the instruction BRAM from 0 on start, drops NOPs, expands REPEAT, stops at HALT; 3 cycles per issue.
// issue_valid holds with a stable word until issue_ready; repeated issues go back-to-back while ready.
module instr_issue_unit #(
    parameter int INSTR_BRAM_DEPTH = 11
) (
    input  logic                        S_AXIS_ACLK,
    input  logic                        S_AXIS_ARESETN,
    input  logic                        VALID_FU2PE,
    output logic [INSTR_BRAM_DEPTH-1:0] instr_rd_addr,
    output logic                        instr_rd_en,
    input  logic [31:0]                 instr_dout,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output logic [31:0]                 issue_data,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_REPEAT = 4'hD;
    localparam logic [3:0] OP_HALT   = 4'hF;

    state_t                      state_q, state_d;
    logic [INSTR_BRAM_DEPTH-1:0] pc_q, pc_d;
    logic [15:0]                 rpt_q, rpt_d;
    logic [31:0]                 data_q, data_d;
    logic                        err_q, err_d;
    logic                        advance;

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            rpt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rpt_q   <= rpt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rpt_d   = rpt_q;
        data_d  = data_q;
        err_d   = err_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (VALID_FU2PE) begin
                    pc_d    = '0;
                    rpt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (instr_dout[31:28])
                    OP_NOP: advance = 1'b1;
                    OP_REPEAT: begin
                        rpt_d   = instr_dout[15:0];
                        advance = 1'b1;
                    end
                    OP_HALT: begin
                        rpt_d   = '0;
                        state_d = S_DONE;
                    end
                    default: begin
                        data_d  = instr_dout;
                        state_d = S_ISSUE;
                    end
                endcase
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    if (rpt_q != 16'd0) rpt_d = rpt_q - 16'd1;
                    else                advance = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The pc never wraps: stepping past the last word is a program error.
        if (advance) begin
            if (pc_q == '1) begin
                err_d   = 1'b1;
                state_d = S_DONE;
            end else begin
                pc_d    = pc_q + INSTR_BRAM_DEPTH'(1);
                state_d = S_FETCH;
            end
        end
    end

    assign instr_rd_en   = (state_q == S_FETCH);
    assign instr_rd_addr = (state_q == S_FETCH) ? pc_q : '0;
    assign issue_valid   = (state_q == S_ISSUE);
    assign issue_data    = data_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;

endmodule
